riscv_alu_mc: RTL and testbench

//  Multi-cycle, parametrised RV32I/RV32M execute ALU; successor to the 1-cycle combinational ALU.

---
 rtl/riscv_alu_mc.sv | 238 +++++++++++++++++++++++
 tb/tb_riscv_alu_mc.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_alu_mc.sv
// rtl/riscv_alu_mc.sv - multi-cycle RV32I/RV32M execute ALU with serial shifter and valid/ready handshakes
// Optional iterative MUL/DIV datapath is built only when RISCV_ALU_MULDIV_EN is defined.
module riscv_alu_mc #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);
    localparam int SW = $clog2(XLEN);
    localparam logic [SW:0]   STEP_W = (SW+1)'(SHIFT_STEP);
    localparam logic [SW-1:0] STEP_N = STEP_W[SW-1:0];

    localparam logic [4:0] OP_AND  = 5'd0,  OP_OR    = 5'd1,  OP_ADD   = 5'd2,  OP_XOR  = 5'd3;
    localparam logic [4:0] OP_SLL  = 5'd4,  OP_SRL   = 5'd5,  OP_SUB   = 5'd6,  OP_SLT  = 5'd7;
    localparam logic [4:0] OP_SLTU = 5'd8,  OP_SRA   = 5'd9,  OP_PASSB = 5'd10, OP_NOR  = 5'd12;
`ifdef RISCV_ALU_MULDIV_EN
    localparam logic [4:0] OP_MUL  = 5'd16, OP_MULH  = 5'd17, OP_MULHSU = 5'd18, OP_MULHU = 5'd19;
    localparam logic [4:0] OP_DIV  = 5'd20, OP_DIVU  = 5'd21, OP_REM    = 5'd22, OP_REMU  = 5'd23;
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};
    localparam int CW = $clog2(XLEN + 2);

    typedef enum logic [1:0] {IDLE, SHIFT, MULDIV, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t          state;
    logic [4:0]      op_q;
    logic [SW-1:0]   sh_rem;
    logic [SW-1:0]   step_amt;
    logic [XLEN-1:0] sh_next;
    logic [XLEN-1:0] quick;
    logic            quick_ill;
    logic            long_shift;
    logic            long_md;
    logic            accept;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready && !flush;

    // Ops that finish on the accept edge, plus classification of the multi-cycle ones
    always_comb begin
        quick      = '0;
        quick_ill  = 1'b0;
        long_shift = 1'b0;
        long_md    = 1'b0;
        case (op)
            OP_AND:   quick = a & b;
            OP_OR:    quick = a | b;
            OP_ADD:   quick = a + b;
            OP_XOR:   quick = a ^ b;
            OP_SUB:   quick = a - b;
            OP_SLT:   quick = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  quick = {{(XLEN-1){1'b0}}, (a < b)};
            OP_PASSB: quick = b;
            OP_NOR:   quick = ~(a | b);
            OP_SLL, OP_SRL, OP_SRA: begin
                quick      = a;
                long_shift = (b[SW-1:0] != '0);
            end
`ifdef RISCV_ALU_MULDIV_EN
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: long_md = 1'b1;
            OP_DIV, OP_REM: begin
                if (b == '0)
                    quick = (op == OP_DIV) ? '1 : a;
                else if ((a == MINV) && (b == '1))
                    quick = (op == OP_DIV) ? MINV : '0;
                else
                    long_md = 1'b1;
            end
            OP_DIVU, OP_REMU: begin
                if (b == '0)
                    quick = (op == OP_DIVU) ? '1 : a;
                else
                    long_md = 1'b1;
            end
`endif
            default:  quick_ill = 1'b1;
        endcase
    end

    // Serial shifter works in place on the result register
    always_comb begin
        if ({1'b0, sh_rem} < STEP_W)
            step_amt = sh_rem;
        else
            step_amt = STEP_N;
        case (op_q)
            OP_SLL:  sh_next = result << step_amt;
            OP_SRL:  sh_next = result >> step_amt;
            default: sh_next = $signed(result) >>> step_amt;
        endcase
    end

`ifdef RISCV_ALU_MULDIV_EN
    logic [XLEN-1:0]   md_hi, md_lo, md_aux;
    logic [CW-1:0]     md_cnt;
    logic              md_neg_q, md_neg_r, md_div, md_last;
    logic              a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag, md_res;
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] mul_next, mul_prod;
    logic              div_ok;

    always_comb begin
        a_sgn    = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_sgn    = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg    = a_sgn && a[XLEN-1];
        b_neg    = b_sgn && b[XLEN-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        mul_sum  = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_aux} : '0);
        mul_next = {mul_sum, md_lo[XLEN-1:1]};
        mul_prod = md_neg_q ? -mul_next : mul_next;
        div_sh   = {md_hi, md_lo[XLEN-1]};
        div_diff = div_sh - {1'b0, md_aux};
        div_ok   = !div_diff[XLEN];
        md_last  = (state == MULDIV) && (md_cnt == CW'(1));
        case (op_q)
            OP_MUL:                       md_res = mul_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: md_res = mul_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              md_res = md_neg_q ? -md_lo : md_lo;
            default:                      md_res = md_neg_r ? -md_hi : md_hi;
        endcase
    end

    // Magnitudes are iterated; the sign fix-up happens when the result is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_hi    <= '0;
            md_lo    <= '0;
            md_aux   <= '0;
            md_cnt   <= '0;
            md_neg_q <= 1'b0;
            md_neg_r <= 1'b0;
            md_div   <= 1'b0;
        end else if (flush) begin
            md_cnt <= '0;
        end else if (accept && long_md) begin
            md_hi    <= '0;
            md_div   <= op[2];
            md_neg_q <= a_neg ^ b_neg;
            md_neg_r <= a_neg;
            if (op[2]) begin
                md_lo  <= a_mag;
                md_aux <= b_mag;
                md_cnt <= CW'(XLEN + 1);
            end else begin
                md_lo  <= b_mag;
                md_aux <= a_mag;
                md_cnt <= CW'(XLEN);
            end
        end else if (state == MULDIV) begin
            md_cnt <= md_cnt - 1'b1;
            if (!md_div) begin
                {md_hi, md_lo} <= mul_next;
            end else if (md_cnt != CW'(1)) begin
                md_hi <= div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
                md_lo <= {md_lo[XLEN-2:0], div_ok};
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            illegal   <= 1'b0;
            op_q      <= '0;
            sh_rem    <= '0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            sh_rem    <= '0;
        end else if (accept) begin
            op_q    <= op;
            illegal <= quick_ill;
            if (long_shift) begin
                state     <= SHIFT;
                out_valid <= 1'b0;
                result    <= a;
                sh_rem    <= b[SW-1:0];
            end
`ifdef RISCV_ALU_MULDIV_EN
            else if (long_md) begin
                state     <= MULDIV;
                out_valid <= 1'b0;
            end
`endif
            else begin
                state     <= DONE;
                out_valid <= 1'b1;
                result    <= quick;
                zero      <= (quick == '0);
            end
        end else begin
            case (state)
                SHIFT: begin
                    result <= sh_next;
                    sh_rem <= sh_rem - step_amt;
                    if (sh_rem == step_amt) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        zero      <= (sh_next == '0);
                    end
                end
`ifdef RISCV_ALU_MULDIV_EN
                MULDIV: if (md_last) begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                    result    <= md_res;
                    zero      <= (md_res == '0);
                end
`endif
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_alu_mc.sv
// tb/tb_riscv_alu_mc.sv - bench for riscv_alu_mc (XLEN=32, SHIFT_STEP=4), follows RISCV_ALU_MULDIV_EN
module tb_riscv_alu_mc;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic        in_ready, out_valid, zero, illegal;
    logic [4:0]  op;
    logic [31:0] a, b, result;
    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] last_res;
    int          last_lat;

    riscv_alu_mc #(.XLEN(32), .SHIFT_STEP(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {illegal, result} from the instruction-set definitions
    function automatic logic [32:0] ref_alu(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        logic        ill;
        logic [63:0] p;
        int          sx, sy, sh;
        r = '0; ill = 1'b0; p = '0;
        sx = x; sy = y; sh = int'(y[4:0]);
        case (o)
            5'd0:  r = x & y;
            5'd1:  r = x | y;
            5'd2:  r = x + y;
            5'd3:  r = x ^ y;
            5'd4:  r = x << sh;
            5'd5:  r = x >> sh;
            5'd6:  r = x - y;
            5'd7:  r = (sx < sy) ? 32'd1 : 32'd0;
            5'd8:  r = (x < y) ? 32'd1 : 32'd0;
            5'd9:  r = 32'(sx >>> sh);
            5'd10: r = y;
            5'd12: r = ~(x | y);
`ifdef RISCV_ALU_MULDIV_EN
            5'd16: begin p = {32'b0, x} * {32'b0, y}; r = p[31:0]; end
            5'd17: begin p = {{32{x[31]}}, x} * {{32{y[31]}}, y}; r = p[63:32]; end
            5'd18: begin p = {{32{x[31]}}, x} * {32'b0, y}; r = p[63:32]; end
            5'd19: begin p = {32'b0, x} * {32'b0, y}; r = p[63:32]; end
            5'd20: r = (y == 0) ? 32'hFFFF_FFFF : (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ? x : 32'(sx / sy);
            5'd21: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            5'd22: r = (y == 0) ? x : (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ? 32'd0 : 32'(sx % sy);
            5'd23: r = (y == 0) ? x : x % y;
`endif
            default: ill = 1'b1;
        endcase
        return {ill, r};
    endfunction

    function automatic int ref_lat(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            5'd4, 5'd5, 5'd9: return (y[4:0] == 0) ? 1 : 1 + (int'(y[4:0]) + 3) / 4;
`ifdef RISCV_ALU_MULDIV_EN
            5'd16, 5'd17, 5'd18, 5'd19: return 33;
            5'd20, 5'd22: return (y == 0 || (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) ? 1 : 34;
            5'd21, 5'd23: return (y == 0) ? 1 : 34;
`endif
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    task automatic do_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
        logic [32:0] exp;
        int          elat, lat;
        exp  = ref_alu(o, x, y);
        elat = ref_lat(o, x, y);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; op = 5'($urandom);
        if (elat > 1) check({tag, "_busy"}, 32'(in_ready), 32'd0);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(elat));
        check({tag, "_result"}, result, exp[31:0]);
        check({tag, "_zero"}, 32'(zero), 32'(exp[31:0] == 0));
        check({tag, "_illegal"}, 32'(illegal), 32'(exp[32]));
        last_res = result;
        last_lat = lat;
        @(posedge clk); #1;
        check({tag, "_consumed"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [4:0] ro;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        do_op(5'd2, 32'd5, 32'd7, "add_5_7");
        check("add_5_7_const", last_res, 32'd12);

        // back-to-back SUB then AND
        @(negedge clk);
        op = 5'd6; a = 32'h1234; b = 32'h1234; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        check("b2b_sub_valid", 32'(out_valid), 32'd1);
        check("b2b_sub_result", result, 32'd0);
        check("b2b_sub_zero", 32'(zero), 32'd1);
        check("b2b_sub_in_ready", 32'(in_ready), 32'd1);
        op = 5'd0; a = 32'hF0; b = 32'h3C;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_and_valid", 32'(out_valid), 32'd1);
        check("b2b_and_result", result, 32'h30);
        check("b2b_and_zero", 32'(zero), 32'd0);
        check("b2b_and_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check("b2b_consumed", 32'(out_valid), 32'd0);

        do_op(5'd9, 32'h8000_0000, 32'd31, "sra_31");
        check("sra_31_const", last_res, 32'hFFFF_FFFF);
        check("sra_31_lat_const", 32'(last_lat), 32'd9);
        do_op(5'd4, 32'hDEAD_BEEF, 32'd0, "sll_0");
        check("sll_0_const", last_res, 32'hDEAD_BEEF);

        // consumer stall
        @(negedge clk);
        op = 5'd2; a = 32'd1; b = 32'hFFFF_FFFF; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_result", result, 32'd0);
            check("stall_zero", 32'(zero), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_handshake", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("stall_single", 32'(out_valid), 32'd0);

`ifdef RISCV_ALU_MULDIV_EN
        do_op(5'd20, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        check("div_m7_2_const", last_res, 32'hFFFF_FFFD);
        check("div_lat_const", 32'(last_lat), 32'd34);
        do_op(5'd22, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        check("rem_m7_2_const", last_res, 32'hFFFF_FFFF);
        do_op(5'd21, 32'd1234, 32'd0, "divu_by0");
        check("divu_by0_const", last_res, 32'hFFFF_FFFF);
        check("divu_by0_lat", 32'(last_lat), 32'd1);
        do_op(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
        check("mulhu_max_const", last_res, 32'hFFFF_FFFE);
        check("mulhu_lat_const", 32'(last_lat), 32'd33);
        do_op(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        do_op(5'd22, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        ro = 5'd20;
`else
        do_op(5'd20, 32'd7, 32'd2, "div_absent");
        check("div_absent_illegal", 32'(illegal), 32'd1);
        ro = 5'd9;
`endif
        do_op(5'd11, 32'd3, 32'd4, "op11_illegal");

        for (int i = 0; i < 60; i++) begin
            logic [4:0] ro2;
            ro2 = 5'($urandom_range(0, 31));
            do_op(ro2, pick(), pick(), $sformatf("rnd%0d_op%0d", i, ro2));
        end

        // flush in the third SHIFT cycle, with a competing in_valid
        @(negedge clk);
        op = 5'd4; a = 32'd1; b = 32'd31; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1; in_valid = 1'b1; op = 5'd2; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        repeat (10) @(posedge clk);
        #1 check("flush_no_result", 32'(out_valid), 32'd0);
        do_op(5'd2, 32'd2, 32'd2, "add_after_flush");

        // asynchronous reset in the middle of a long op
        @(negedge clk);
        op = ro; a = 32'hFFFF_FFF9; b = 32'd31; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_result", result, 32'd0);
        check("arst_zero", 32'(zero), 32'd1);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_idle", 32'(out_valid), 32'd0);
        do_op(5'd2, 32'd2, 32'd2, "add_after_reset");
        check("add_after_reset_const", last_res, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
